// File: rtl/pipe_skid_64.sv
// pipe_skid_64: two-entry registered skid buffer with valid/ready on both sides.
// The head word lives in main_r and drives out_data directly; a word arriving
// while the head is stalled is parked in skid_r. in_ready, out_valid and
// occupancy are decodes of the state register only, so no input reaches any
// output combinationally.
module pipe_skid_64 #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  // State encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_r;
  state_t           next_state_s;
  logic [WIDTH-1:0] main_r;
  logic [WIDTH-1:0] skid_r;

  logic in_acc_s;
  logic out_acc_s;
  logic load_main_s;
  logic main_from_skid_s;
  logic load_skid_s;

  assign in_acc_s  = in_valid & in_ready;
  assign out_acc_s = out_valid & out_ready;
  assign out_data  = main_r;

  // Output decode from the state register only.
  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    occupancy = 2'd0;
    case (state_r)
      EMPTY: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        occupancy = 2'd0;
      end
      HALF: begin
        in_ready  = 1'b1;
        out_valid = 1'b1;
        occupancy = 2'd1;
      end
      FULL: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
        occupancy = 2'd2;
      end
      default: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        occupancy = 2'd0;
      end
    endcase
  end

  // Next-state and data-load decisions; flush discards everything, including
  // a word offered in the same cycle.
  always_comb begin
    next_state_s     = state_r;
    load_main_s      = 1'b0;
    main_from_skid_s = 1'b0;
    load_skid_s      = 1'b0;
    if (flush) begin
      next_state_s = EMPTY;
    end else begin
      case (state_r)
        EMPTY: begin
          if (in_acc_s) begin
            load_main_s  = 1'b1;
            next_state_s = HALF;
          end else begin
            next_state_s = EMPTY;
          end
        end
        HALF: begin
          if (in_acc_s && out_acc_s) begin
            load_main_s  = 1'b1;
            next_state_s = HALF;
          end else if (in_acc_s) begin
            load_skid_s  = 1'b1;
            next_state_s = FULL;
          end else if (out_acc_s) begin
            next_state_s = EMPTY;
          end else begin
            next_state_s = HALF;
          end
        end
        FULL: begin
          if (out_acc_s) begin
            load_main_s      = 1'b1;
            main_from_skid_s = 1'b1;
            next_state_s     = HALF;
          end else begin
            next_state_s = FULL;
          end
        end
        default: begin
          next_state_s = EMPTY;
        end
      endcase
    end
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= EMPTY;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Data registers load only on accept events; they keep stale contents when emptied.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_r <= {WIDTH{1'b0}};
      skid_r <= {WIDTH{1'b0}};
    end else begin
      if (load_main_s) begin
        main_r <= main_from_skid_s ? skid_r : in_data;
      end else begin
        main_r <= main_r;
      end
      if (load_skid_s) begin
        skid_r <= in_data;
      end else begin
        skid_r <= skid_r;
      end
    end
  end

endmodule

// File: tb/tb_pipe_skid_64.sv
// Self-checking bench for pipe_skid_64: a FIFO-queue model of the buffer,
// a per-cycle compare process, and directed scenarios with literal checks.
module tb_pipe_skid_64;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [1:0]  occupancy;

  int errors = 0;
  int checks = 0;
  bit run_cmp = 1'b0;

  logic [63:0] q[$];        // words held, head first
  logic [63:0] out_log[$];  // every word the model saw consumed

  pipe_skid_64 #(.WIDTH(64)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: at most two words, FIFO order, flush empties, reset empties.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      q.delete();
    end else begin
      bit oa, ia;
      oa = (q.size() > 0) && out_ready;
      ia = in_valid && (q.size() < 2) && !flush;
      if (oa) out_log.push_back(q.pop_front());
      if (flush) q.delete();
      else if (ia) q.push_back(in_data);
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (run_cmp) begin
      if (!reset) begin
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_occupancy", {62'd0, occupancy}, 64'd0);
        chk("rst_out_data", out_data, 64'd0);
      end else begin
        chk("occupancy", {62'd0, occupancy}, 64'(q.size()));
        chk("out_valid", {63'd0, out_valid}, {63'd0, q.size() != 0});
        chk("in_ready", {63'd0, in_ready}, {63'd0, q.size() < 2});
        if (q.size() != 0) chk("out_data", out_data, q[0]);
      end
    end
  end

  // Apply inputs at a negedge, then advance to the next negedge.
  task automatic cyc(input logic iv, input logic [63:0] d, input logic ordy, input logic fl);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    @(negedge clk);
  endtask

  initial begin
    logic        r_iv, r_or, r_fl;
    logic [63:0] r_d;
    int          log_base;

    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 64'd0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("init_out_valid", {63'd0, out_valid}, 64'd0);
    chk("init_in_ready", {63'd0, in_ready}, 64'd1);
    chk("init_occupancy", {62'd0, occupancy}, 64'd0);
    chk("init_out_data", out_data, 64'd0);
    reset = 1'b1;
    run_cmp = 1'b1;

    // Streaming at full rate.
    cyc(1'b1, 64'h1, 1'b1, 1'b0);
    chk("stream_d1", out_data, 64'h1);
    chk("stream_occ1", {62'd0, occupancy}, 64'd1);
    cyc(1'b1, 64'h2, 1'b1, 1'b0);
    chk("stream_d2", out_data, 64'h2);
    cyc(1'b1, 64'h3, 1'b1, 1'b0);
    chk("stream_d3", out_data, 64'h3);
    chk("stream_occ3", {62'd0, occupancy}, 64'd1);
    cyc(1'b0, 64'h0, 1'b1, 1'b0);
    chk("stream_drained", {63'd0, out_valid}, 64'd0);
    chk("stream_log_n", 64'(out_log.size()), 64'd3);
    chk("stream_log2", out_log[2], 64'h3);

    // Backpressure fill, rejected third word, then ordered drain.
    cyc(1'b1, 64'hA, 1'b0, 1'b0);
    cyc(1'b1, 64'hB, 1'b0, 1'b0);
    chk("bp_occ2", {62'd0, occupancy}, 64'd2);
    chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
    chk("bp_head_a", out_data, 64'hA);
    cyc(1'b1, 64'hC, 1'b0, 1'b0);
    chk("bp_c_rejected", {62'd0, occupancy}, 64'd2);
    cyc(1'b1, 64'hC, 1'b1, 1'b0);
    chk("bp_head_b", out_data, 64'hB);
    chk("bp_ready_back", {63'd0, in_ready}, 64'd1);
    cyc(1'b1, 64'hC, 1'b1, 1'b0);
    chk("bp_head_c", out_data, 64'hC);
    cyc(1'b0, 64'h0, 1'b1, 1'b0);
    chk("bp_empty", {62'd0, occupancy}, 64'd0);

    // Simultaneous accept on both sides in HALF.
    cyc(1'b1, 64'h10, 1'b0, 1'b0);
    chk("sim_head_10", out_data, 64'h10);
    cyc(1'b1, 64'h20, 1'b1, 1'b0);
    chk("sim_head_20", out_data, 64'h20);
    chk("sim_occ1", {62'd0, occupancy}, 64'd1);
    cyc(1'b0, 64'h0, 1'b1, 1'b0);

    // Flush in FULL with a word on offer.
    log_base = out_log.size();
    cyc(1'b1, 64'h5, 1'b0, 1'b0);
    cyc(1'b1, 64'h6, 1'b0, 1'b0);
    chk("fl_full", {62'd0, occupancy}, 64'd2);
    cyc(1'b1, 64'h7, 1'b0, 1'b1);
    chk("fl_occ0", {62'd0, occupancy}, 64'd0);
    chk("fl_out_valid", {63'd0, out_valid}, 64'd0);
    cyc(1'b0, 64'h0, 1'b1, 1'b0);
    chk("fl_no_7", {63'd0, out_valid}, 64'd0);
    chk("fl_nothing_out", 64'(out_log.size()), 64'(log_base));

    // Asynchronous reset between clock edges while FULL.
    cyc(1'b1, 64'h5, 1'b0, 1'b0);
    cyc(1'b1, 64'h6, 1'b0, 1'b0);
    in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("ar_out_valid", {63'd0, out_valid}, 64'd0);
    chk("ar_in_ready", {63'd0, in_ready}, 64'd1);
    chk("ar_out_data", out_data, 64'd0);
    chk("ar_occupancy", {62'd0, occupancy}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    cyc(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    chk("ar_first_word", out_data, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("ar_occ1", {62'd0, occupancy}, 64'd1);
    cyc(1'b0, 64'h0, 1'b1, 1'b0);

    // Randomized stress with rare flushes.
    for (int i = 0; i < 10000; i++) begin
      r_iv = 1'($urandom_range(0, 1));
      r_or = 1'($urandom_range(0, 1));
      r_fl = ($urandom_range(0, 63) == 0);
      r_d  = {$urandom, $urandom};
      cyc(r_iv, r_d, r_or, r_fl);
    end
    repeat (3) cyc(1'b0, 64'h0, 1'b1, 1'b0);
    chk("stress_drained", {62'd0, occupancy}, 64'd0);

    run_cmp = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_skid_64.md
# pipe_skid_64

Two-entry registered skid buffer that carries a WIDTH-bit word between pipeline stages with a valid/ready handshake on both sides. It is the consuming end of our load-enable register stages: the downstream stage applies backpressure through `out_ready`, and the block absorbs one in-flight word so that `in_ready` is a pure register output. It sits between the execute and memory stages of the 64-bit datapath and also serves as the generic stall-capable stage register. It sustains one word per cycle with no combinational path from `out_ready` to `in_ready`.

## Interface
- `WIDTH`, default 64, payload width in bits.
- `clk` input 1: single clock; all state changes on its rising edge.
- `reset` input 1: asynchronous, active-low reset (asserted when 0).
- `flush` input 1: synchronous discard of all held words.
- `in_valid` input 1: upstream offers `in_data`.
- `in_ready` output 1: block can accept a word this cycle; driven from state only.
- `in_data` input WIDTH: upstream payload.
- `out_valid` output 1: `out_data` holds a valid word.
- `out_ready` input 1: downstream accepts `out_data` this cycle.
- `out_data` output WIDTH: head word, driven directly from the main register.
- `occupancy` output 2: number of held words (0, 1 or 2).

## Operation
- Storage: main register (head, drives `out_data`) and skid register (second word), each WIDTH bits.
- Accept events: `in_acc = in_valid & in_ready`; `out_acc = out_valid & out_ready`.
- State EMPTY (occupancy 0): `in_ready`=1, `out_valid`=0.
  - `in_acc` loads main; next state HALF.
- State HALF (occupancy 1): `in_ready`=1, `out_valid`=1.
  - `in_acc & out_acc`: main <= `in_data`; stay in HALF.
  - `in_acc` only: skid <= `in_data`; next state FULL.
  - `out_acc` only: next state EMPTY.
- State FULL (occupancy 2): `in_ready`=0, `out_valid`=1.
  - `out_acc`: main <= skid; next state HALF.
  - Otherwise hold.
- Words leave in arrival order. No word is duplicated or dropped except on flush.
- Data registers load only on the events above. They are not cleared when emptied, so `out_data` is don't-care while `out_valid`=0.
- `flush`=1 overrides all events:
  - next state is EMPTY;
  - a word offered in the same cycle is not stored;
  - `out_acc` in that cycle still counts as consumed by downstream.
- Reset (`reset`=0, any time including mid-transfer):
  - state EMPTY, main=0, skid=0;
  - outputs take their reset values immediately, asynchronously: `out_valid`=0, `in_ready`=1, `out_data`=0, `occupancy`=0.
- Reset release is sampled synchronously. The first accept is possible on the first rising edge with `reset`=1.

## Timing
- Latency from `in_acc` to `out_valid` is 1 cycle: a word accepted at edge N is presented after edge N.
- Throughput is 1 word/cycle while `out_ready` is held at 1.
- `in_ready` falls the cycle after the skid fills. It rises the cycle after a FULL-state `out_acc`.
- `in_ready`, `out_valid`, `out_data` and `occupancy` are register outputs (or decodes of the state register only). There is no combinational path from any input to any output.
- Upstream must hold `in_data` stable only in the cycle it asserts `in_valid`. `in_valid` may drop without acceptance.
- Downstream may toggle `out_ready` freely. While `out_valid`=1 and `out_ready`=0, `out_data` is held stable.

## Test plan
- Reset and streaming: assert `reset`=0 for 2 cycles, then check `out_valid`=0, `in_ready`=1, `occupancy`=0. Stream 0x1, 0x2, 0x3 with `out_ready`=1 -> outputs 0x1, 0x2, 0x3 on consecutive cycles, each one cycle after input; `occupancy` stays 1.
- Backpressure fill: with `out_ready`=0, send 0xA then 0xB -> `occupancy`=2 and `in_ready`=0. Offer 0xC -> not accepted. Raise `out_ready` -> outputs 0xA, 0xB, then 0xC, in order.
- Simultaneous in/out in HALF: with 0x10 held, present 0x20 while `out_ready`=1 -> 0x10 consumed, next `out_data`=0x20, `occupancy` stays 1.
- Flush: in FULL (0x5, 0x6), assert `flush` while `in_valid`=1 with 0x7 -> next cycle `occupancy`=0, `out_valid`=0, and 0x7 is never output.
- Async reset mid-operation: in FULL, drop `reset` between clock edges -> `out_valid`=0, `in_ready`=1 and `out_data`=0 before the next edge. After release, the first word sent (0xFFFF_FFFF_FFFF_FFFF) emerges intact.
- Randomized stress: random `in_valid`/`out_ready` over 10k cycles with a scoreboard -> output sequence equals input sequence, `occupancy` never exceeds 2, and no accept occurs when `in_ready`=0.
